// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the sequenced wide adder controller.
//   SLICE_W   - width of the shared carry-lookahead slice
//   state_t   - controller state encoding
//   idx_width - width of the slice index counter (never below one bit)
package add_seq_ctrl_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/cla16_lcu.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups whose group
// carries come from a two-level lookahead carry unit.
//   a, b  - 16-bit addends
//   cin   - carry into bit 0
//   s     - 16-bit sum
//   cout  - carry out of bit 15
//   pout  - block propagate (all 16 bits propagate)
//   gout  - block generate (carry out independent of cin)
module cla16_lcu (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        pout,
    output logic        gout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    logic        rc;

    always_comb begin
        // NOTE: every variable gets a value before any conditional or loop
        // logic, so no path can leave one unassigned and infer a latch.
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        rc = 1'b0;

        for (int i = 0; i < 4; i++) begin
            gp[i] = &p[4*i +: 4];
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end

        // Lookahead carry unit: each group carry is a flat sum of products.
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

        // Bit carries inside each 4-bit group start from the group carry.
        for (int i = 0; i < 4; i++) begin
            rc = gc[i];
            for (int j = 0; j < 4; j++) begin
                c[4*i+j] = rc;
                rc = g[4*i+j] | (p[4*i+j] & rc);
            end
        end

        s    = p ^ c;
        cout = gc[4];
        pout = &gp;
        gout = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract controller that time-multiplexes one cla16_lcu slice.
// Operands are latched on an accepted start, processed one 16-bit slice
// per cycle LSB first with the carry registered between slices, and the
// result is presented with a one-cycle valid pulse.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start/ready - request handshake (accepted only in IDLE)
//   op_sub      - 0: a+b+cin, 1: a-b-cin (cin is borrow-in)
//   a, b, cin   - operands, sampled on accepted start
//   busy        - high while running or presenting a result
//   valid       - one-cycle pulse, result outputs valid
//   s           - result, held until the next accepted start
//   cout        - final carry (subtract: 1 = no borrow)
//   ovf, zero   - signed overflow, result-is-zero
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter  int NSLICE = 4,
    localparam int W      = SLICE_W * NSLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int               IDX_W    = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]                idx_q;
    logic [NSLICE-1:0][SLICE_W-1:0]  op_a_q;
    logic [NSLICE-1:0][SLICE_W-1:0]  op_b_q;
    logic [NSLICE-1:0][SLICE_W-1:0]  s_q;
    logic [NSLICE-1:0][SLICE_W-1:0]  s_next;
    logic                            carry_q;
    logic                            cout_q;
    logic                            ovf_q;
    logic                            zero_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;
    logic               last;

    assign last = (idx_q == LAST_IDX);

    // W-to-16 operand mux driven only by registered state, so start has
    // no combinational path into the slice.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = op_a_q[i];
                slice_b = op_b_q[i];
            end
        end
    end

    // Result with the current slice merged in; used for the zero flag on
    // the final slice, before s_q itself has been updated.
    always_comb begin
        s_next = s_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                s_next[i] = slice_s;
            end
        end
    end

    cla16_lcu u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .pout (),
        .gout ()
    );

    // NOTE: flops use non-blocking (<=) so every register samples the
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        valid   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                valid   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + ~borrow_in.
                        op_a_q  <= a;
                        op_b_q  <= op_sub ? ~b : b;
                        carry_q <= op_sub ? ~cin : cin;
                        s_q     <= '0;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    s_q     <= s_next;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last) begin
                        // Flags use the (possibly inverted) B operand, so a
                        // single rule covers both add and subtract.
                        cout_q <= slice_cout;
                        ovf_q  <= (op_a_q[NSLICE-1][SLICE_W-1] == op_b_q[NSLICE-1][SLICE_W-1])
                               && (slice_s[SLICE_W-1] != op_a_q[NSLICE-1][SLICE_W-1]);
                        zero_q <= (s_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: a 4-slice and a 1-slice instance,
// a cycle-level reference model compared every cycle, and directed
// vectors with hand-computed results.
module tb_add_seq_ctrl;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        st[2];
    logic        osub[2];
    logic        ci[2];
    logic [63:0] av[2];
    logic [63:0] bv[2];

    logic        rdy4, bsy4, vld4, co4, ov4, z4;
    logic [63:0] s4;
    logic        rdy1, bsy1, vld1, co1, ov1, z1;
    logic [15:0] s1;

    int n_checks = 0;
    int n_err = 0;

    int   m_left[2];
    res_t m_out[2];
    res_t m_pend[2];
    int   nsl[2];
    int   wid[2];

    always #5 clk = ~clk;

    add_seq_ctrl #(.NSLICE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .ready(rdy4), .op_sub(osub[0]),
        .a(av[0]), .b(bv[0]), .cin(ci[0]), .busy(bsy4), .valid(vld4),
        .s(s4), .cout(co4), .ovf(ov4), .zero(z4)
    );

    add_seq_ctrl #(.NSLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .ready(rdy1), .op_sub(osub[1]),
        .a(av[1][15:0]), .b(bv[1][15:0]), .cin(ci[1]), .busy(bsy1), .valid(vld1),
        .s(s1), .cout(co1), .ovf(ov1), .zero(z1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain W-bit arithmetic: result, carry/no-borrow, signed overflow, zero.
    function automatic res_t ref_op(input int w, input logic sub, input logic [63:0] a_in,
                                    input logic [63:0] b_in, input logic c_in);
        res_t r;
        logic [64:0] full;
        logic [63:0] mask, x, y;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = a_in & mask;
        y = b_in & mask;
        if (sub) full = {1'b0, x} - {1'b0, y} - {64'd0, c_in};
        else     full = {1'b0, x} + {1'b0, y} + {64'd0, c_in};
        r.s    = full[63:0] & mask;
        r.cout = sub ? ~full[w] : full[w];
        if (sub) r.ovf = (x[w-1] != y[w-1]) && (r.s[w-1] != x[w-1]);
        else     r.ovf = (x[w-1] == y[w-1]) && (r.s[w-1] != x[w-1]);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    // Model: an accepted request keeps the unit busy for NSLICE+1 cycles,
    // the last of which presents the result.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_left[d] = 0;
                m_out[d]  = '0;
                m_pend[d] = '0;
            end else if (m_left[d] == 0) begin
                if (st[d]) begin
                    m_pend[d] = ref_op(wid[d], osub[d], av[d], bv[d], ci[d]);
                    m_left[d] = nsl[d] + 1;
                end
            end else begin
                m_left[d] = m_left[d] - 1;
                if (m_left[d] == 1) m_out[d] = m_pend[d];
            end
        end
    end

    task automatic cmp(input int d, input logic rdy, input logic bsy, input logic vld,
                       input logic [63:0] s_act, input logic c, input logic o, input logic z);
        int   el;
        res_t eo;
        el = rst_n ? m_left[d] : 0;
        eo = rst_n ? m_out[d] : '0;
        check($sformatf("dut%0d_ready", d), {63'd0, rdy}, {63'd0, el == 0});
        check($sformatf("dut%0d_busy", d),  {63'd0, bsy}, {63'd0, el != 0});
        check($sformatf("dut%0d_valid", d), {63'd0, vld}, {63'd0, el == 1});
        if (el <= 1) begin
            check($sformatf("dut%0d_s", d),    s_act,       eo.s);
            check($sformatf("dut%0d_cout", d), {63'd0, c},  {63'd0, eo.cout});
            check($sformatf("dut%0d_ovf", d),  {63'd0, o},  {63'd0, eo.ovf});
            check($sformatf("dut%0d_zero", d), {63'd0, z},  {63'd0, eo.zero});
        end
    endtask

    always @(negedge clk) begin
        cmp(0, rdy4, bsy4, vld4, s4, co4, ov4, z4);
        cmp(1, rdy1, bsy1, vld1, {48'd0, s1}, co1, ov1, z1);
    end

    // One operation with hand-computed expectations and latency.
    task automatic run_op(input int d, input logic sub, input logic [63:0] a_in,
                          input logic [63:0] b_in, input logic c_in, input logic [63:0] es,
                          input logic ec, input logic eov, input logic ez);
        int lat;
        @(negedge clk);
        check("op_ready", {63'd0, (d == 1) ? rdy1 : rdy4}, 64'd1);
        st[d] = 1'b1; osub[d] = sub; av[d] = a_in; bv[d] = b_in; ci[d] = c_in;
        @(negedge clk);
        // Scramble inputs after acceptance; the result must not move.
        st[d] = 1'b0; osub[d] = ~sub; av[d] = ~a_in; bv[d] = ~b_in; ci[d] = ~c_in;
        lat = 1;
        while (!((d == 1) ? vld1 : vld4) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("op_latency", lat, nsl[d] + 1);
        check("op_s",    (d == 1) ? {48'd0, s1} : s4, es);
        check("op_cout", {63'd0, (d == 1) ? co1 : co4}, {63'd0, ec});
        check("op_ovf",  {63'd0, (d == 1) ? ov1 : ov4}, {63'd0, eov});
        check("op_zero", {63'd0, (d == 1) ? z1 : z4},   {63'd0, ez});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int n_valid;
        nsl[0] = 4; wid[0] = 64;
        nsl[1] = 1; wid[1] = 16;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; osub[d] = 1'b0; ci[d] = 1'b0; av[d] = '0; bv[d] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, rdy4}, 64'd1);
        check("rst_s", s4, 64'd0);
        #2 rst_n = 1'b1;

        // Reset while slice 2 is being processed.
        @(negedge clk);
        st[0] = 1'b1; av[0] = 64'h1111_2222_3333_4444; bv[0] = 64'h5555_6666_7777_8888;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", {63'd0, bsy4}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {63'd0, rdy4}, 64'd1);
        check("mid_rst_busy",  {63'd0, bsy4}, 64'd0);
        check("mid_rst_valid", {63'd0, vld4}, 64'd0);
        check("mid_rst_s",     s4, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed vectors, 4 slices.
        run_op(0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        run_op(0, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op(0, 1'b1, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op(0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op(0, 1'b1, 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(0, 1'b1, 64'h1234, 64'h1234, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);

        // Directed vectors, 1 slice.
        run_op(1, 1'b0, 64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0);
        run_op(1, 1'b1, 64'h0000, 64'h0001, 1'b0, 64'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op(1, 1'b0, 64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0, 1'b1);

        // start held high with operands changing every cycle.
        n_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            st[0]   = 1'b1;
            osub[0] = i[0];
            ci[0]   = i[1];
            av[0]   = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
            bv[0]   = {32'(i * 7), 32'hFEDC_0000 + 32'(i)};
            @(negedge clk);
            if (vld4) n_valid++;
        end
        st[0] = 1'b0;
        check("hs_valid_count", n_valid, 4);
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
